// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, capture-time register-file
// bypass and load-use hazard detection. Feeds the execute ALU directly.
module id_ex_stage #(
    parameter int unsigned N = 32,
    parameter int unsigned R = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         id_valid,
    input  logic [3:0]   id_opcode,
    input  logic [R-1:0] id_rs1,
    input  logic [R-1:0] id_rs2,
    input  logic [R-1:0] id_rd,
    input  logic [N-1:0] id_rd1,
    input  logic [N-1:0] id_rd2,
    input  logic         id_use_imm,
    input  logic [N-1:0] id_imm,
    input  logic         id_reg_write,
    input  logic         id_mem_read,
    input  logic         flush,
    input  logic         exm_reg_write,
    input  logic [R-1:0] exm_rd,
    input  logic [N-1:0] exm_result,
    input  logic         wb_reg_write,
    input  logic [R-1:0] wb_rd,
    input  logic [N-1:0] wb_data,
    output logic         stall,
    output logic         ex_valid,
    output logic [3:0]   ex_opcode,
    output logic [R-1:0] ex_rd,
    output logic         ex_reg_write,
    output logic         ex_mem_read,
    output logic [N-1:0] ex_operandA,
    output logic [N-1:0] ex_operandB
);

    // Unused ALU code: a bubble produces a zero result.
    localparam logic [3:0] OPC_BUBBLE = 4'b1111;

    logic         valid_q,     valid_d;
    logic [3:0]   opcode_q,    opcode_d;
    logic [R-1:0] rs1_q,       rs1_d;
    logic [R-1:0] rs2_q,       rs2_d;
    logic [R-1:0] rd_q,        rd_d;
    logic         use_imm_q,   use_imm_d;
    logic         reg_write_q, reg_write_d;
    logic         mem_read_q,  mem_read_d;
    logic [N-1:0] a_raw_q,     a_raw_d;
    logic [N-1:0] b_raw_q,     b_raw_d;

    // Load in EX whose destination is read by the decode instruction.
    always_comb begin
        stall = id_valid & valid_q & mem_read_q & (rd_q != '0) & ~flush &
                ((id_rs1 == rd_q) | (~id_use_imm & (id_rs2 == rd_q)));
    end

    // Next EX contents: bubble unless a live, unstalled, unflushed instruction.
    always_comb begin
        valid_d     = 1'b0;
        opcode_d    = OPC_BUBBLE;
        rs1_d       = '0;
        rs2_d       = '0;
        rd_d        = '0;
        use_imm_d   = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        a_raw_d     = '0;
        b_raw_d     = '0;
        if (id_valid && !flush && !stall) begin
            valid_d     = 1'b1;
            opcode_d    = id_opcode;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            use_imm_d   = id_use_imm;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            a_raw_d     = (wb_reg_write && wb_rd == id_rs1 && id_rs1 != '0) ? wb_data : id_rd1;
            if (id_use_imm) begin
                b_raw_d = id_imm;
            end else begin
                b_raw_d = (wb_reg_write && wb_rd == id_rs2 && id_rs2 != '0) ? wb_data : id_rd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            opcode_q    <= OPC_BUBBLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            a_raw_q     <= '0;
            b_raw_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            opcode_q    <= opcode_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            use_imm_q   <= use_imm_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            a_raw_q     <= a_raw_d;
            b_raw_q     <= b_raw_d;
        end
    end

    // EX/MEM result beats MEM/WB data; r0 is never forwarded.
    always_comb begin
        ex_operandA = '0;
        ex_operandB = '0;
        if (valid_q) begin
            if (exm_reg_write && exm_rd == rs1_q && rs1_q != '0) begin
                ex_operandA = exm_result;
            end else if (wb_reg_write && wb_rd == rs1_q && rs1_q != '0) begin
                ex_operandA = wb_data;
            end else begin
                ex_operandA = a_raw_q;
            end
            if (use_imm_q) begin
                ex_operandB = b_raw_q;
            end else if (exm_reg_write && exm_rd == rs2_q && rs2_q != '0) begin
                ex_operandB = exm_result;
            end else if (wb_reg_write && wb_rd == rs2_q && rs2_q != '0) begin
                ex_operandB = wb_data;
            end else begin
                ex_operandB = b_raw_q;
            end
        end
    end

    assign ex_valid     = valid_q;
    assign ex_opcode    = opcode_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed stimulus pushes expected
// values tagged with the cycle they must appear in; a negedge monitor checks them.
module tb_id_ex_stage;

    localparam int unsigned N = 32;
    localparam int unsigned R = 4;

    localparam int S_VALID = 0;
    localparam int S_OPC   = 1;
    localparam int S_RD    = 2;
    localparam int S_RW    = 3;
    localparam int S_MR    = 4;
    localparam int S_A     = 5;
    localparam int S_B     = 6;
    localparam int S_STALL = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         id_valid;
    logic [3:0]   id_opcode;
    logic [R-1:0] id_rs1, id_rs2, id_rd;
    logic [N-1:0] id_rd1, id_rd2, id_imm;
    logic         id_use_imm, id_reg_write, id_mem_read, flush;
    logic         exm_reg_write;
    logic [R-1:0] exm_rd;
    logic [N-1:0] exm_result;
    logic         wb_reg_write;
    logic [R-1:0] wb_rd;
    logic [N-1:0] wb_data;
    logic         stall, ex_valid, ex_reg_write, ex_mem_read;
    logic [3:0]   ex_opcode;
    logic [R-1:0] ex_rd;
    logic [N-1:0] ex_operandA, ex_operandB;

    id_ex_stage #(.N(N), .R(R)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_use_imm(id_use_imm), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_operandA(ex_operandA), .ex_operandB(ex_operandB)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_VALID: observe = 32'(ex_valid);
            S_OPC:   observe = 32'(ex_opcode);
            S_RD:    observe = 32'(ex_rd);
            S_RW:    observe = 32'(ex_reg_write);
            S_MR:    observe = 32'(ex_mem_read);
            S_A:     observe = ex_operandA;
            S_B:     observe = ex_operandB;
            default: observe = 32'(stall);
        endcase
    endfunction

    // dc = 0: expected this cycle (combinational); dc = 1: after the next edge.
    task automatic exp_at(input int dc, input int sel, input logic [31:0] v, input string tag);
        exp_t e;
        e.cyc = cyc + dc;
        e.sel = sel;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                chk(sb[i].tag, observe(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_id();
        id_valid = 0; id_opcode = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rd1 = 0; id_rd2 = 0; id_use_imm = 0; id_imm = 0;
        id_reg_write = 0; id_mem_read = 0; flush = 0;
    endtask

    task automatic clr_fwd();
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic issue_load(input logic [R-1:0] rd);
        clr_id();
        id_valid = 1; id_opcode = 4'd0; id_rs1 = 4'd1; id_rd1 = 32'h100;
        id_rd = rd; id_reg_write = 1; id_mem_read = 1;
    endtask

    initial begin
        rst = 1;
        clr_id();
        clr_fwd();
        tick();
        tick();

        // Reset with a live decode instruction
        id_valid = 1; id_opcode = 4'd0; id_rs1 = 4'd2; id_rd1 = 32'd5; id_rd = 4'd3; id_reg_write = 1;
        exp_at(1, S_VALID, 0, "rst_valid");
        exp_at(1, S_OPC, 32'hF, "rst_opcode");
        exp_at(1, S_A, 0, "rst_opA");
        exp_at(1, S_B, 0, "rst_opB");
        exp_at(1, S_STALL, 0, "rst_stall");
        exp_at(1, S_RW, 0, "rst_regwrite");
        exp_at(1, S_RD, 0, "rst_rd");
        tick();
        rst = 0;
        clr_id();
        tick();

        // Pass-through
        id_valid = 1; id_opcode = 4'd0; id_rs1 = 4'd2; id_rd1 = 32'd5;
        id_rs2 = 4'd3; id_rd2 = 32'd7; id_rd = 4'd8; id_reg_write = 1;
        exp_at(0, S_STALL, 0, "pass_stall");
        exp_at(1, S_A, 32'd5, "pass_opA");
        exp_at(1, S_B, 32'd7, "pass_opB");
        exp_at(1, S_VALID, 1, "pass_valid");
        exp_at(1, S_OPC, 0, "pass_opcode");
        exp_at(1, S_RD, 8, "pass_rd");
        exp_at(1, S_RW, 1, "pass_regwrite");
        tick();
        clr_id();
        tick();

        // Forward priority: EX/MEM over WB, then WB alone, then r0 never forwarded
        id_valid = 1; id_opcode = 4'd2; id_rs1 = 4'd4; id_rd1 = 32'h11;
        id_rs2 = 4'd0; id_rd2 = 32'h22; id_rd = 4'd1; id_reg_write = 1;
        tick();
        exm_reg_write = 1; exm_rd = 4'd4; exm_result = 32'hAA;
        wb_reg_write = 1; wb_rd = 4'd4; wb_data = 32'hBB;
        exp_at(0, S_A, 32'hAA, "fwd_exm_prio");
        exp_at(0, S_B, 32'h22, "fwd_rs2_zero");
        tick();
        exm_reg_write = 0; wb_data = 32'hBC;
        exp_at(0, S_A, 32'hBC, "fwd_wb");
        id_rs1 = 4'd0; id_rd1 = 32'h33;
        tick();
        exm_reg_write = 1; exm_rd = 4'd0; exm_result = 32'hAA;
        wb_rd = 4'd0; wb_data = 32'hBB;
        id_valid = 0;
        exp_at(0, S_A, 32'h33, "fwd_r0_raw");
        tick();
        clr_fwd();
        clr_id();
        tick();

        // Capture-time bypass of a same-cycle register-file write
        id_valid = 1; id_opcode = 4'd1; id_rs2 = 4'd6; id_rd2 = 32'd1;
        wb_reg_write = 1; wb_rd = 4'd6; wb_data = 32'h1234;
        exp_at(1, S_B, 32'h1234, "cap_bypass_opB");
        exp_at(1, S_A, 0, "cap_bypass_opA");
        tick();
        clr_id();
        clr_fwd();
        tick();

        // Load-use: one stall, one bubble, then WB forward of load data
        issue_load(4'd5);
        tick();
        clr_id();
        id_valid = 1; id_opcode = 4'd1; id_rs1 = 4'd5; id_rd1 = 32'hDEAD;
        id_rs2 = 4'd2; id_rd2 = 32'd3; id_rd = 4'd7; id_reg_write = 1;
        exp_at(0, S_STALL, 1, "lu_stall");
        exp_at(0, S_MR, 1, "lu_load_in_ex");
        exp_at(0, S_RD, 5, "lu_load_rd");
        tick();
        exp_at(0, S_STALL, 0, "lu_stall_one_cycle");
        exp_at(0, S_VALID, 0, "lu_bubble_valid");
        exp_at(0, S_RW, 0, "lu_bubble_regwrite");
        exp_at(0, S_OPC, 32'hF, "lu_bubble_opcode");
        tick();
        clr_id();
        wb_reg_write = 1; wb_rd = 4'd5; wb_data = 32'h5A5A;
        exp_at(0, S_VALID, 1, "lu_dep_valid");
        exp_at(0, S_OPC, 1, "lu_dep_opcode");
        exp_at(0, S_A, 32'h5A5A, "lu_dep_opA_wb");
        exp_at(0, S_B, 32'd3, "lu_dep_opB");
        exp_at(0, S_RD, 7, "lu_dep_rd");
        tick();
        clr_fwd();
        tick();

        // Flush wins over a load-use hazard
        issue_load(4'd5);
        tick();
        clr_id();
        id_valid = 1; id_rs1 = 4'd5; id_rd = 4'd2; id_reg_write = 1; flush = 1;
        exp_at(0, S_STALL, 0, "flush_no_stall");
        exp_at(1, S_VALID, 0, "flush_bubble");
        exp_at(1, S_RW, 0, "flush_bubble_regwrite");
        tick();
        clr_id();
        tick();

        // Immediate operand B: no rs2 hazard, never forwarded
        issue_load(4'd9);
        tick();
        clr_id();
        id_valid = 1; id_opcode = 4'd3; id_rs1 = 4'd1; id_rd1 = 32'h44;
        id_rs2 = 4'd9; id_rd2 = 32'h77; id_use_imm = 1; id_imm = 32'h10;
        exp_at(0, S_STALL, 0, "imm_no_stall");
        tick();
        clr_id();
        exm_reg_write = 1; exm_rd = 4'd9; exm_result = 32'hEE;
        exp_at(0, S_B, 32'h10, "imm_opB");
        exp_at(0, S_A, 32'h44, "imm_opA");
        exp_at(0, S_VALID, 1, "imm_valid");
        tick();
        clr_fwd();
        tick();

        // Reset during a stall: bubble, no carry-over
        issue_load(4'd5);
        tick();
        clr_id();
        id_valid = 1; id_opcode = 4'd4; id_rs1 = 4'd5; id_rd1 = 32'h66; id_rd = 4'd3;
        rst = 1;
        exp_at(0, S_STALL, 1, "rst_mid_stall_hi");
        tick();
        rst = 0;
        exp_at(0, S_STALL, 0, "rst_mid_stall_drop");
        exp_at(0, S_VALID, 0, "rst_mid_bubble");
        exp_at(0, S_MR, 0, "rst_mid_memread");
        exp_at(1, S_VALID, 1, "rst_mid_dep_valid");
        exp_at(1, S_A, 32'h66, "rst_mid_dep_opA");
        tick();
        clr_id();
        tick();

        // Hazard on both sources: a single stall cycle
        issue_load(4'd6);
        tick();
        clr_id();
        id_valid = 1; id_opcode = 4'd5; id_rs1 = 4'd6; id_rs2 = 4'd6;
        id_rd1 = 32'h1; id_rd2 = 32'h2; id_rd = 4'd8; id_reg_write = 1;
        exp_at(0, S_STALL, 1, "both_stall");
        tick();
        exp_at(0, S_STALL, 0, "both_stall_once");
        tick();
        clr_id();
        exp_at(0, S_VALID, 1, "both_dep_valid");
        exp_at(0, S_OPC, 5, "both_dep_opcode");
        tick();
        tick();

        foreach (sb[i]) begin
            n_err++;
            $display("FAIL %s: expectation for cycle %0d never checked", sb[i].tag, sb[i].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
